// File: rtl/disease_pkg.sv
// Shared definitions for the disease-model run controller and its neighbours.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package disease_pkg;

  // Default node count, shared by the network, the run controller and the bench.
  localparam int DEF_NUM_NODES = 10;

  // Run sequencer states. The encodings are fixed so that other blocks and
  // debug tools can decode the state register directly.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } run_state_e;

endpackage

// File: rtl/node_tick_counter.sv
// Per-node saturating counter of ticks spent infected.
// Latency: count updates on the edge after clr/inc are sampled.
// Backpressure: none; the counter holds at all-ones instead of wrapping.
module node_tick_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; increment stops once every bit is set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/epidemic_run_ctrl.sv
// Run sequencer for the disease network: load pattern, settle, run N ticks, count infected ticks.
// Latency: loadState one cycle after start, tickEn from the third cycle, done one cycle after the last tick.
// Backpressure: none; start is ignored outside IDLE and abort cancels a run without a done pulse.
module epidemic_run_ctrl
  import disease_pkg::*;
#(
  parameter int NUM_NODES = DEF_NUM_NODES,
  parameter int TICK_W    = 32,
  parameter int CNT_W     = 32,
  // Must satisfy 2**ADDR_W >= NUM_NODES.
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_NODES-1:0] cfgInitStates,
  input  logic [TICK_W-1:0]    cfgNumTicks,
  input  logic                 cfgStopOnExtinct,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_NODES-1:0] nodeStates,
  output logic                 loadState,
  output logic [NUM_NODES-1:0] initState,
  output logic                 tickEn,
  output logic                 busy,
  output logic                 done,
  output logic                 extinct,
  output logic [TICK_W-1:0]    tickCount,
  input  logic [ADDR_W-1:0]    rdAddr,
  output logic [CNT_W-1:0]     rdData
);

  localparam int RD_DEPTH = 2 ** ADDR_W;

  run_state_e state;
  run_state_e state_nxt;

  logic [TICK_W-1:0] num_ticks_q;
  logic              stop_q;
  logic              start_take;
  logic              in_run;
  logic              last_tick;
  logic              extinct_now;

  // Readback view: real counters in the low entries, zeros above NUM_NODES.
  logic [CNT_W-1:0]  cnt_view [RD_DEPTH];

  assign start_take  = (state == ST_IDLE) && start;
  assign in_run      = (state == ST_RUN);
  assign last_tick   = ((tickCount + TICK_W'(1)) == num_ticks_q);
  assign extinct_now = stop_q && (nodeStates == '0);

  // Network-facing strobes are pure decodes of the state register.
  assign loadState = (state == ST_LOAD);
  assign tickEn    = in_run;
  assign busy      = (state == ST_LOAD) || (state == ST_SETTLE) || in_run;
  assign done      = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides any completion in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_nxt = abort ? ST_IDLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (num_ticks_q == '0) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (last_tick || extinct_now) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latched run configuration, tick counter and extinction flag. A RUN cycle
  // is always counted, even when abort ends the run on that cycle, because
  // the network already saw tickEn for it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      initState   <= '0;
      num_ticks_q <= '0;
      stop_q      <= 1'b0;
      tickCount   <= '0;
      extinct     <= 1'b0;
    end else if (start_take) begin
      initState   <= cfgInitStates;
      num_ticks_q <= cfgNumTicks;
      stop_q      <= cfgStopOnExtinct;
      tickCount   <= '0;
      extinct     <= 1'b0;
    end else if (in_run) begin
      tickCount <= tickCount + TICK_W'(1);
      if (extinct_now && !abort) begin
        extinct <= 1'b1;
      end
    end
  end

  // One saturating counter per node, cleared when a run is accepted.
  for (genvar i = 0; i < RD_DEPTH; i++) begin : g_node
    if (i < NUM_NODES) begin : g_cnt
      node_tick_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_take),
        .inc   (in_run && nodeStates[i]),
        .count (cnt_view[i])
      );
    end else begin : g_pad
      assign cnt_view[i] = '0;
    end
  end

  // Registered readback; out-of-range addresses land on the zero padding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdData <= '0;
    end else begin
      rdData <= cnt_view[rdAddr];
    end
  end

endmodule

// File: tb/tb_epidemic_run_ctrl.sv
// Directed bench for epidemic_run_ctrl with hand-computed expectations.
// Latency: inputs driven 1 ns after a rising edge, outputs checked 1 ns after the next one.
// Backpressure: not applicable; every step is a fixed number of cycles.
module tb_epidemic_run_ctrl;

  localparam int NUM_NODES = 10;
  localparam int TICK_W    = 32;
  localparam int CNT_W     = 3;
  localparam int ADDR_W    = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_NODES-1:0] cfgInitStates;
  logic [TICK_W-1:0]    cfgNumTicks;
  logic                 cfgStopOnExtinct;
  logic                 start;
  logic                 abort;
  logic [NUM_NODES-1:0] nodeStates;
  logic                 loadState;
  logic [NUM_NODES-1:0] initState;
  logic                 tickEn;
  logic                 busy;
  logic                 done;
  logic                 extinct;
  logic [TICK_W-1:0]    tickCount;
  logic [ADDR_W-1:0]    rdAddr;
  logic [CNT_W-1:0]     rdData;

  int n_checks;
  int n_fail;

  epidemic_run_ctrl #(
    .NUM_NODES (NUM_NODES),
    .TICK_W    (TICK_W),
    .CNT_W     (CNT_W),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfgInitStates    (cfgInitStates),
    .cfgNumTicks      (cfgNumTicks),
    .cfgStopOnExtinct (cfgStopOnExtinct),
    .start            (start),
    .abort            (abort),
    .nodeStates       (nodeStates),
    .loadState        (loadState),
    .initState        (initState),
    .tickEn           (tickEn),
    .busy             (busy),
    .done             (done),
    .extinct          (extinct),
    .tickCount        (tickCount),
    .rdAddr           (rdAddr),
    .rdData           (rdData)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Present an address, wait the one-cycle readback latency, compare.
  task automatic rd(input string tag, input int addr, input int expv);
    rdAddr = ADDR_W'(addr);
    tick();
    chk(tag, 32'(rdData), 32'(expv));
  endtask

  // Pulse start for one edge with the given configuration; returns in cycle 1.
  task automatic go(input int init_pat, input int nticks, input logic stop);
    cfgInitStates    = NUM_NODES'(init_pat);
    cfgNumTicks      = TICK_W'(nticks);
    cfgStopOnExtinct = stop;
    start            = 1'b1;
    tick();
    start            = 1'b0;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    cfgInitStates    = '0;
    cfgNumTicks      = '0;
    cfgStopOnExtinct = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    nodeStates       = '0;
    rdAddr           = '0;
    tick();
    tick();

    // Reset state.
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_load",      32'(loadState), 32'd0);
    chk("rst_tick_en",   32'(tickEn),    32'd0);
    chk("rst_tick_cnt",  32'(tickCount), 32'd0);
    chk("rst_extinct",   32'(extinct),   32'd0);
    chk("rst_init",      32'(initState), 32'd0);
    chk("rst_rd",        32'(rdData),    32'd0);
    rst_n = 1'b1;
    tick();

    // Normal run: 5 ticks, nodes 0 and 1 infected throughout.
    nodeStates = 10'b00_0000_0011;
    go(1, 5, 1'b0);
    chk("norm_c1_load",  32'(loadState), 32'd1);
    chk("norm_c1_init",  32'(initState), 32'h001);
    chk("norm_c1_busy",  32'(busy),      32'd1);
    chk("norm_c1_ten",   32'(tickEn),    32'd0);
    tick();
    chk("norm_c2_load",  32'(loadState), 32'd0);
    chk("norm_c2_ten",   32'(tickEn),    32'd0);
    chk("norm_c2_busy",  32'(busy),      32'd1);
    for (int c = 3; c <= 7; c++) begin
      tick();
      chk("norm_run_ten",  32'(tickEn),    32'd1);
      chk("norm_run_done", 32'(done),      32'd0);
      chk("norm_run_cnt",  32'(tickCount), 32'(c - 3));
    end
    tick();
    chk("norm_c8_done",  32'(done),      32'd1);
    chk("norm_c8_ten",   32'(tickEn),    32'd0);
    chk("norm_c8_busy",  32'(busy),      32'd0);
    chk("norm_c8_cnt",   32'(tickCount), 32'd5);
    chk("norm_c8_ext",   32'(extinct),   32'd0);
    tick();
    chk("norm_c9_done",  32'(done),      32'd0);
    rd("norm_rd0",  0, 5);
    rd("norm_rd1",  1, 5);
    rd("norm_rd2",  2, 0);
    rd("norm_rd12", 12, 0);

    // Extinction: node 0 infected for 3 RUN cycles, then nobody.
    nodeStates = 10'h001;
    go(10'h3FF, 100, 1'b1);
    tick();             // cycle 2, SETTLE
    tick();             // cycle 3, RUN 1
    tick();             // cycle 4, RUN 2
    tick();             // cycle 5, RUN 3
    chk("ext_c5_cnt",    32'(tickCount), 32'd2);
    tick();             // cycle 6, RUN 4
    nodeStates = '0;
    chk("ext_c6_ten",    32'(tickEn),    32'd1);
    chk("ext_c6_ext",    32'(extinct),   32'd0);
    tick();             // cycle 7, DONE
    chk("ext_done",      32'(done),      32'd1);
    chk("ext_flag",      32'(extinct),   32'd1);
    chk("ext_cnt",       32'(tickCount), 32'd4);
    chk("ext_ten",       32'(tickEn),    32'd0);
    tick();
    chk("ext_hold",      32'(extinct),   32'd1);
    rd("ext_rd0", 0, 3);
    rd("ext_rd1", 1, 0);

    // Abort on the 2nd RUN cycle; extinct is cleared by the new start.
    nodeStates = 10'h200;
    go(10'h155, 20, 1'b0);
    chk("abt_ext_clr",   32'(extinct),   32'd0);
    tick();             // cycle 2
    tick();             // cycle 3, RUN 1
    tick();             // cycle 4, RUN 2
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_busy",      32'(busy),      32'd0);
    chk("abt_ten",       32'(tickEn),    32'd0);
    chk("abt_done",      32'(done),      32'd0);
    chk("abt_cnt",       32'(tickCount), 32'd2);
    chk("abt_init",      32'(initState), 32'h155);
    tick();
    chk("abt_done2",     32'(done),      32'd0);
    rd("abt_rd9", 9, 2);

    // Start during SETTLE and during DONE is ignored.
    nodeStates = '0;
    go(10'h0AA, 3, 1'b0);
    cfgInitStates = 10'h3C3;
    cfgNumTicks   = 32'd9;
    start = 1'b1;
    tick();             // cycle 2, start seen in SETTLE
    start = 1'b0;
    tick();             // cycle 3, RUN 1
    chk("ign_init",      32'(initState), 32'h0AA);
    chk("ign_load",      32'(loadState), 32'd0);
    tick();             // cycle 4
    tick();             // cycle 5
    tick();             // cycle 6, DONE
    chk("ign_done",      32'(done),      32'd1);
    chk("ign_cnt",       32'(tickCount), 32'd3);
    start = 1'b1;
    tick();             // start seen in DONE
    start = 1'b0;
    chk("ign_dn_busy",   32'(busy),      32'd0);
    chk("ign_dn_load",   32'(loadState), 32'd0);
    tick();
    chk("ign_dn_load2",  32'(loadState), 32'd0);

    // Abort on the final tick wins over completion.
    go(10'h001, 2, 1'b0);
    tick();             // cycle 2
    tick();             // cycle 3, RUN 1
    tick();             // cycle 4, RUN 2 (last)
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abl_done",      32'(done),      32'd0);
    chk("abl_busy",      32'(busy),      32'd0);
    chk("abl_cnt",       32'(tickCount), 32'd2);

    // Abort in IDLE does nothing visible.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abi_busy",      32'(busy),      32'd0);
    chk("abi_cnt",       32'(tickCount), 32'd2);

    // Extinction on the last tick: done with extinct set.
    nodeStates = 10'h001;
    go(10'h001, 2, 1'b1);
    tick();             // cycle 2
    tick();             // cycle 3, RUN 1
    tick();             // cycle 4, RUN 2
    nodeStates = '0;
    tick();             // cycle 5
    chk("exl_done",      32'(done),      32'd1);
    chk("exl_ext",       32'(extinct),   32'd1);
    chk("exl_cnt",       32'(tickCount), 32'd2);

    // Zero ticks: LOAD, SETTLE, DONE with no tickEn.
    tick();
    go(10'h002, 0, 1'b0);
    chk("zero_load",     32'(loadState), 32'd1);
    tick();
    chk("zero_c2_ten",   32'(tickEn),    32'd0);
    tick();
    chk("zero_done",     32'(done),      32'd1);
    chk("zero_ten",      32'(tickEn),    32'd0);
    chk("zero_cnt",      32'(tickCount), 32'd0);
    chk("zero_ext",      32'(extinct),   32'd0);
    tick();

    // Saturation: 10 ticks with every node infected on a 3-bit counter.
    nodeStates = 10'h3FF;
    go(10'h3FF, 10, 1'b0);
    for (int c = 2; c <= 13; c++) begin
      tick();
    end
    chk("sat_done",      32'(done),      32'd1);
    chk("sat_cnt",       32'(tickCount), 32'd10);
    for (int a = 0; a < NUM_NODES; a++) begin
      rd("sat_rd", a, 7);
    end

    // Reset in the middle of a run.
    go(10'h3FF, 50, 1'b0);
    tick();             // cycle 2
    tick();             // cycle 3, RUN
    tick();             // cycle 4, RUN
    chk("mrst_pre_ten",  32'(tickEn),    32'd1);
    rst_n = 1'b0;
    tick();
    chk("mrst_ten0",     32'(tickEn),    32'd0);
    tick();
    chk("mrst_busy",     32'(busy),      32'd0);
    chk("mrst_done",     32'(done),      32'd0);
    chk("mrst_load",     32'(loadState), 32'd0);
    chk("mrst_cnt",      32'(tickCount), 32'd0);
    chk("mrst_init",     32'(initState), 32'd0);
    chk("mrst_rd",       32'(rdData),    32'd0);
    rst_n = 1'b1;
    tick();
    chk("mrst_ten1",     32'(tickEn),    32'd0);
    for (int a = 0; a < NUM_NODES; a++) begin
      rd("mrst_rdn", a, 0);
      chk("mrst_ten_rd", 32'(tickEn), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
